// File: rtl/dmem_access_ctrl_if.sv
// Request/response and word-memory port bundle between the MEM stage and the data memory controller.
// The slave modport is the controller's view; master is the datapath plus memory side.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_ewr;
  logic              mem_erd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ewr, mem_erd, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ewr, mem_erd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data memory access controller: byte/half/word loads and stores onto a word-only memory port,
// with read-modify-write for sub-word stores and an error response for illegal requests.
module dmem_access_ctrl #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t              r_state;
  logic                r_we;
  logic [1:0]          r_size;
  logic [1:0]          r_lane;
  logic                r_signed;
  logic [DATA_W-1:0]   r_wdata;

  logic                r_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_mem_ewr;
  logic                r_mem_erd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [ADDR_W-1:0]   w_idx;
  logic                w_err;
  logic [4:0]          w_sh_b;
  logic [4:0]          w_sh_h;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_merge;

  // Request classification works on the live request; it only feeds register inputs.
  always_comb begin
    w_idx = {2'b00, bus.req_addr[ADDR_W-1:2]};
    w_err = (bus.req_size == 2'b11)
         || (bus.req_size == 2'b01 && bus.req_addr[0])
         || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
         || (w_idx >= ADDR_W'(DEPTH));
  end

  // Lane extraction for loads and lane merge for sub-word stores, from the latched request.
  always_comb begin
    w_sh_b = {r_lane, 3'b000};
    w_sh_h = {r_lane[1], 4'b0000};
    w_byte = 8'(bus.mem_rdata >> w_sh_b);
    w_half = 16'(bus.mem_rdata >> w_sh_h);
    w_load = bus.mem_rdata;
    w_merge = r_wdata;
    case (r_size)
      2'b00: begin
        w_load  = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        w_merge = (bus.mem_rdata & ~(DATA_W'(8'hFF) << w_sh_b))
                | (DATA_W'(r_wdata[7:0]) << w_sh_b);
      end
      2'b01: begin
        w_load  = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        w_merge = (bus.mem_rdata & ~(DATA_W'(16'hFFFF) << w_sh_h))
                | (DATA_W'(r_wdata[15:0]) << w_sh_h);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_lane       <= 2'b00;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_ewr    <= 1'b0;
      r_mem_erd    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_lane   <= bus.req_addr[1:0];
            r_signed <= bus.req_signed;
            r_wdata  <= bus.req_wdata;
            r_ready  <= 1'b0;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!bus.req_we || bus.req_size != 2'b10) begin
              r_state    <= S_READ;
              r_mem_erd  <= 1'b1;
              r_mem_addr <= w_idx;
            end else begin
              r_state     <= S_WRITE;
              r_mem_ewr   <= 1'b1;
              r_mem_addr  <= w_idx;
              r_mem_wdata <= bus.req_wdata;
            end
          end
        end
        S_READ: begin
          r_mem_erd <= 1'b0;
          if (r_we) begin
            r_state     <= S_WRITE;
            r_mem_ewr   <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state      <= S_RESP;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
            r_resp_err   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_mem_ewr    <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_ewr    = r_mem_ewr;
  assign bus.mem_erd    = r_mem_erd;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected responses, a monitor
// pops and compares data, error flag and response cycle; a small word memory model sits on the port.
module tb_dmem_access_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] mem [0:DEPTH-1];

  // Word memory model: combinational read, write on the clock edge.
  assign bus.mem_rdata = (bus.mem_addr < ADDR_W'(DEPTH)) ? mem[bus.mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_erd) rd_count <= rd_count + 1;
    if (bus.mem_ewr) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      wr_count   <= wr_count + 1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (bus.mem_erd && bus.mem_ewr) begin
      errors++;
      $display("FAIL rd_wr_overlap at cycle %0d", cyc);
    end
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_resp at cycle %0d rdata %08h err %0b", cyc, bus.resp_rdata, bus.resp_err);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ready(input string name, output bit ok);
    int guard = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      checks++; errors++; ok = 1'b0;
      $display("FAIL %s_ready_timeout: req_ready %0b expected 1", name, bus.req_ready);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
  endtask

  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    bit   ok;
    wait_ready(name, ok);
    if (!ok) return;
    drive(we, addr, size, sgn, wdata);
    e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_resp_timeout: %0d responses outstanding expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int   c, rd0, wr0;
    bit   ok;
    exp_t e;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_size = 2'b00; bus.req_signed = 1'b0; bus.req_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_en", {30'd0, bus.mem_erd, bus.mem_ewr}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    wr0 = wr_count;
    issue("st_word", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    drain("st_word");
    chk("st_word_waddr", last_waddr, 32'd4);
    chk("st_word_wdata", last_wdata, 32'hDEADBEEF);
    chk("st_word_pulses", 32'(wr_count - wr0), 32'd1);
    issue("ld_word", 1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    drain("ld_word");

    wr0 = wr_count; rd0 = rd_count;
    issue("st_byte", 1'b1, 32'h12, 2'b00, 1'b0, 32'hFFFFFF55, 32'h0, 1'b0, 3);
    drain("st_byte");
    chk("st_byte_wdata", last_wdata, 32'hDE55BEEF);
    chk("st_byte_rw", 32'((rd_count - rd0) * 16 + (wr_count - wr0)), 32'h11);
    issue("ld_word_rmw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDE55BEEF, 1'b0, 2);
    issue("ld_half_s", 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    issue("ld_half_u", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 32'h0000BEEF, 1'b0, 2);
    issue("ld_byte3_s", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    issue("ld_byte2_u", 1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 32'h00000055, 1'b0, 2);
    issue("ld_byte1_u", 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'h000000BE, 1'b0, 2);
    issue("ld_half1_s", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'hFFFFDE55, 1'b0, 2);
    drain("loads");

    issue("st_half1", 1'b1, 32'h12, 2'b01, 1'b0, 32'hABCD1234, 32'h0, 1'b0, 3);
    drain("st_half1");
    chk("st_half1_wdata", last_wdata, 32'h1234BEEF);
    issue("st_word_last", 1'b1, 32'h7C, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    issue("ld_word_last", 1'b0, 32'h7C, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    drain("last_word");

    // Busy: req_valid held through a load; second request only accepted in the next IDLE cycle.
    wait_ready("busy", ok);
    if (ok) begin
      c = cyc;
      drive(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      e.name = "busy_1"; e.rdata = 32'h1234BEEF; e.err = 1'b0; e.cyc = c + 2;
      sb.push_back(e);
      e.name = "busy_2"; e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.cyc = c + 5;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.req_addr = 32'h7C;
      repeat (3) @(posedge clk);
      #1 bus.req_valid = 1'b0;
      drain("busy");
    end

    wr0 = wr_count; rd0 = rd_count;
    issue("err_word_mis", 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("err_half_mis", 1'b1, 32'h11, 2'b01, 1'b0, 32'h77, 32'h0, 1'b1, 1);
    issue("err_size3", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("err_range", 1'b0, 32'h80, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("err_range_st", 1'b1, 32'h81, 2'b00, 1'b0, 32'h99, 32'h0, 1'b1, 1);
    drain("errors");
    chk("err_no_mem_access", 32'((rd_count - rd0) + (wr_count - wr0)), 32'd0);

    // Reset during the WRITE cycle of a byte store must drop the write and the response.
    wait_ready("rst_mid", ok);
    if (ok) begin
      drive(1'b1, 32'h10, 2'b00, 1'b0, 32'h000000AA);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_ewr_before", 32'(bus.mem_ewr), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ewr_after", 32'(bus.mem_ewr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mid_mem", mem[4], 32'h1234BEEF);
    end
    issue("ld_after_rst", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h1234BEEF, 1'b0, 2);
    drain("ld_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
